// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and counter-width helper for the button debouncer
package btn_pkg;

  typedef enum logic [2:0] {
    RELEASED   = 3'd0,
    PRESS_PEND = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    REL_PEND   = 3'd4
  } btn_state_t;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debounce FSM, hold/repeat counters
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic repeat_o,
  output logic evt_d_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam int RM1_INT = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  localparam logic          IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DC_V     = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HM1_V    = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RM1_V    = RW'(RM1_INT);

  logic          sync1_q, sync2_q;
  logic          s;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          held_q, held_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;
  logic          rep_q, rep_d;

  // Pressed-high view of the synchronised pin.
  assign s = sync2_q ^ IDLE_PIN;

  // Next-state logic: debounce both edges, then time hold and repeat while pressed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    rcnt_d  = rcnt_q;
    held_d  = held_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    hold_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_PEND;
          cnt_d   = CW'(1);
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DC_V) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hcnt_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = REL_PEND;
          cnt_d   = CW'(1);
          held_d  = 1'b0;
        end else if (hcnt_q == HM1_V) begin
          state_d = HELD;
          hold_d  = 1'b1;
          rcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = REL_PEND;
          cnt_d   = CW'(1);
          held_d  = 1'b1;
        end else if (REPEAT_CYCLES > 0) begin
          if (rcnt_q == RM1_V) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      REL_PEND: begin
        if (s) begin
          // Bounce during release: resume where we were, counters stay frozen.
          state_d = held_q ? HELD : PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DC_V) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == HELD) || (state_d == REL_PEND);
  end

  // State, counters and registered outputs; reset returns to idle with the pin at its inactive level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
      state_q <= RELEASED;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      rcnt_q  <= '0;
      held_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      rcnt_q  <= rcnt_d;
      held_q  <= held_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign hold_o    = hold_q;
  assign repeat_o  = rep_q;
  assign evt_d_o   = press_d | rel_d | hold_d | rep_d;

endmodule

// File: rtl/multi_button_debounce.sv
// rtl/multi_button_debounce.sv - N_CH independent debounced buttons with a shared event flag
module multi_button_debounce
  import btn_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_hold,
  output logic [N_CH-1:0] btn_repeat,
  output logic            any_event
);

  logic [N_CH-1:0] evt_d;
  logic            any_event_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[ch]),
      .level_o  (btn_level[ch]),
      .press_o  (btn_press[ch]),
      .release_o(btn_release[ch]),
      .hold_o   (btn_hold[ch]),
      .repeat_o (btn_repeat[ch]),
      .evt_d_o  (evt_d[ch])
    );
  end

  // Register the OR of next-cycle pulses so any_event lines up with the pulse flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= |evt_d;
    end
  end

  assign any_event = any_event_q;

endmodule
